pum_apb_mem_ctrl: RTL and testbench

//   Parametrised APB slave fronting a register file and NBANKS memory banks; shared with the PUM accelerator wide port.

---
 rtl/pum_apb_pkg.sv | 30 +++
 rtl/pum_apb_mem_ctrl_if.sv | 21 ++
 rtl/pum_mem_bank.sv | 29 ++
 rtl/pum_apb_mem_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_pum_apb_mem_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pum_apb_pkg.sv
// Shared types for the PUM/APB memory controller: FSM states, address-decode
// record and helpers deriving lane geometry from the bank/row widths.
package pum_apb_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  typedef struct packed {
    logic        is_reg;
    logic [5:0]  idx;
    logic [31:0] row;
    logic [15:0] col;
    logic [7:0]  bank;
    logic [7:0]  lane;
    logic        err;
  } addr_dec_t;

  function automatic int lanes_per_bank(input int bank_w);
    return bank_w / WORD_W;
  endfunction

  function automatic int col_width(input int pum_w);
    return $clog2(pum_w / WORD_W);
  endfunction

endpackage

// File: rtl/pum_apb_mem_ctrl_if.sv
// APB slave-side bus bundle used by the PUM memory controller.
interface APB_BUS;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport Slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

  modport Master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );
endinterface

// File: rtl/pum_mem_bank.sv
// One memory bank: single RW port, per-32b-lane write enables, registered read
// that returns the pre-write contents when read and write hit the same row.
module pum_mem_bank #(
  parameter  int BANK_W = 256,
  parameter  int DEPTH  = 16384,
  localparam int LANES  = BANK_W / 32,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  input  logic              rd,
  input  logic [LANES-1:0]  we,
  input  logic [BANK_W-1:0] wdata,
  output logic [BANK_W-1:0] rdata
);

  logic [BANK_W-1:0] mem [DEPTH];
  logic [BANK_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rd) rdata_q <= mem[addr];
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) mem[addr][i*32 +: 32] <= wdata[i*32 +: 32];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/pum_apb_mem_ctrl.sv
// APB slave over a register file and NBANKS memory banks shared with the PUM wide port.
// Optional PUM_APB_PERF_CNT_EN adds read-only PUM read/write and forced-grant counters.
module pum_apb_mem_ctrl
  import pum_apb_pkg::*;
#(
  parameter  int NBANKS    = 4,
  parameter  int BANK_W    = 256,
  parameter  int DEPTH     = 16384,
  parameter  int NREGS     = 32,
  parameter  int APB_AW    = 22,
  parameter  int STALL_MAX = 8,
  localparam int PUM_W     = NBANKS * BANK_W,
  localparam int ROW_AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  APB_BUS.Slave             apb,
  input  logic [ROW_AW-1:0] pum_mem_addr,
  input  logic [PUM_W-1:0]  pum_mem_wdata,
  input  logic              pum_mem_rd,
  input  logic              pum_mem_wr,
  output logic              pum_mem_ready,
  output logic [PUM_W-1:0]  pum_mem_rdata,
  output logic              pum_mem_rvalid
);

  localparam int LPB = lanes_per_bank(BANK_W);
  localparam int CW  = col_width(PUM_W);
  localparam int CWW = (CW > 0) ? CW : 1;
  localparam int SW  = $clog2(STALL_MAX + 1);
`ifdef PUM_APB_PERF_CNT_EN
  localparam int NREGS_VIS = NREGS + 3;
`else
  localparam int NREGS_VIS = NREGS;
`endif
  localparam logic [LPB-1:0] ONE_LANE = 1;

  state_e          state_q, state_d;
  logic            pready_q, pready_d;
  logic            pslverr_q, pslverr_d;
  logic [31:0]     prdata_q, prdata_d;
  logic            resp_mem_q, resp_mem_d;
  logic [CWW-1:0]  sel_col_q, sel_col_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic            rvalid_q, rvalid_d;
  logic [31:0]     regs_q [NREGS];
  logic [31:0]     regs_d [NREGS];

  addr_dec_t       dec;
  logic [APB_AW-1:0] a;
  logic [31:0]     word, col;
  logic [31:0]     reg_rd, mem_lane;
  logic            apb_req, pum_req, grant_apb, apb_go;
  logic            pum_rd_acc, pum_wr_acc, apb_mem_rd, apb_mem_wr, reg_wr;
  logic [ROW_AW-1:0] bank_addr;
  logic            bank_rd;
  logic [LPB-1:0]  bank_we    [NBANKS];
  logic [BANK_W-1:0] bank_wdata [NBANKS];
  logic            unused_ok;

  always_comb begin
    a          = apb.paddr[APB_AW-1:0];
    word       = 32'(a[APB_AW-2:2]);
    col        = word & ((32'd1 << CW) - 32'd1);
    dec        = '0;
    dec.is_reg = a[APB_AW-1];
    dec.idx    = a[7:2];
    dec.row    = word >> CW;
    dec.col    = 16'(col);
    dec.bank   = 8'(col / LPB);
    dec.lane   = 8'(col % LPB);
    if (dec.is_reg) dec.err = int'(dec.idx) >= NREGS_VIS;
    else            dec.err = dec.row >= 32'(DEPTH);
  end

  // PUM wins unless APB has waited STALL_MAX cycles in its access phase.
  assign apb_req    = (state_q == IDLE) && apb.psel && apb.penable;
  assign pum_req    = pum_mem_rd | pum_mem_wr;
  assign grant_apb  = !pum_req || (stall_q == SW'(STALL_MAX));
  assign apb_go     = apb_req && grant_apb;
  assign pum_rd_acc = pum_mem_rd && !apb_go;
  assign pum_wr_acc = pum_mem_wr && !apb_go;
  assign apb_mem_rd = apb_go && !dec.is_reg && !dec.err && !apb.pwrite;
  assign apb_mem_wr = apb_go && !dec.is_reg && !dec.err && apb.pwrite;
  assign reg_wr     = apb_go && dec.is_reg && !dec.err && apb.pwrite;

  assign bank_addr  = apb_go ? dec.row[ROW_AW-1:0] : pum_mem_addr;
  assign bank_rd    = pum_rd_acc || apb_mem_rd;

  genvar gi;
  generate
    for (gi = 0; gi < NBANKS; gi++) begin : g_bank
      always_comb begin
        bank_we[gi]    = '0;
        bank_wdata[gi] = apb_go ? {LPB{apb.pwdata}} : pum_mem_wdata[gi*BANK_W +: BANK_W];
        if (pum_wr_acc) bank_we[gi] = '1;
        else if (apb_mem_wr && (int'(dec.bank) == gi)) bank_we[gi] = ONE_LANE << dec.lane;
      end

      pum_mem_bank #(
        .BANK_W (BANK_W),
        .DEPTH  (DEPTH)
      ) u_bank (
        .clk   (clk),
        .addr  (bank_addr),
        .rd    (bank_rd),
        .we    (bank_we[gi]),
        .wdata (bank_wdata[gi]),
        .rdata (pum_mem_rdata[gi*BANK_W +: BANK_W])
      );
    end
  endgenerate

  assign mem_lane = pum_mem_rdata[{sel_col_q, 5'b0} +: 32];

`ifdef PUM_APB_PERF_CNT_EN
  logic [31:0] rd_cnt_q, wr_cnt_q, frc_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      frc_cnt_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_q + 32'(pum_rd_acc);
      wr_cnt_q  <= wr_cnt_q + 32'(pum_wr_acc);
      frc_cnt_q <= frc_cnt_q + 32'(apb_go && pum_req);
    end
  end
`endif

  always_comb begin
    reg_rd = '0;
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (int'(dec.idx) == i) reg_rd = regs_q[i];
      if (reg_wr && int'(dec.idx) == i) regs_d[i] = apb.pwdata;
    end
`ifdef PUM_APB_PERF_CNT_EN
    if (int'(dec.idx) == NREGS)     reg_rd = rd_cnt_q;
    if (int'(dec.idx) == NREGS + 1) reg_rd = wr_cnt_q;
    if (int'(dec.idx) == NREGS + 2) reg_rd = frc_cnt_q;
`endif
  end

  always_comb begin
    state_d    = state_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    prdata_d   = prdata_q;
    resp_mem_d = 1'b0;
    sel_col_d  = sel_col_q;
    stall_d    = stall_q;
    rvalid_d   = pum_rd_acc;
    case (state_q)
      IDLE: begin
        if (apb_req) begin
          if (grant_apb) begin
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = dec.err;
            if (dec.err) begin
              prdata_d = '0;
            end else if (!apb.pwrite) begin
              if (dec.is_reg) begin
                prdata_d = reg_rd;
              end else begin
                resp_mem_d = 1'b1;
                sel_col_d  = CWW'(dec.col);
              end
            end
          end else if (stall_q != SW'(STALL_MAX)) begin
            stall_d = stall_q + SW'(1);
          end
        end
      end
      RESP: begin
        // Latch the bank lane now; later PUM reads overwrite the bank output register.
        state_d = IDLE;
        stall_d = '0;
        if (resp_mem_q) prdata_d = mem_lane;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      resp_mem_q <= 1'b0;
      sel_col_q  <= '0;
      stall_q    <= '0;
      rvalid_q   <= 1'b0;
      regs_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      prdata_q   <= prdata_d;
      resp_mem_q <= resp_mem_d;
      sel_col_q  <= sel_col_d;
      stall_q    <= stall_d;
      rvalid_q   <= rvalid_d;
      regs_q     <= regs_d;
    end
  end

  // Dropping psel mid-transfer suppresses the response.
  assign apb.pready     = pready_q & apb.psel;
  assign apb.pslverr    = pslverr_q & apb.psel;
  assign apb.prdata     = resp_mem_q ? mem_lane : prdata_q;
  assign pum_mem_ready  = !apb_go;
  assign pum_mem_rvalid = rvalid_q;

  assign unused_ok = ^{apb.paddr[31:APB_AW], a[1:0]};

endmodule

// File: tb/tb_pum_apb_mem_ctrl.sv
// Directed bench for pum_apb_mem_ctrl: APB/PUM scoreboards, arbitration stall, reset in RESP.
// Honours PUM_APB_PERF_CNT_EN to pick the expected behaviour of the counter indices.
module tb_pum_apb_mem_ctrl;

  localparam int PUM_W  = 1024;
  localparam int ROW_AW = 14;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } apb_exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ROW_AW-1:0] pum_mem_addr;
  logic [PUM_W-1:0]  pum_mem_wdata;
  logic              pum_mem_rd;
  logic              pum_mem_wr;
  logic              pum_mem_ready;
  logic [PUM_W-1:0]  pum_mem_rdata;
  logic              pum_mem_rvalid;

  APB_BUS bus ();

  pum_apb_mem_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .apb            (bus),
    .pum_mem_addr   (pum_mem_addr),
    .pum_mem_wdata  (pum_mem_wdata),
    .pum_mem_rd     (pum_mem_rd),
    .pum_mem_wr     (pum_mem_wr),
    .pum_mem_ready  (pum_mem_ready),
    .pum_mem_rdata  (pum_mem_rdata),
    .pum_mem_rvalid (pum_mem_rvalid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;
  int last_rl = 0;
  apb_exp_t          apb_q [$];
  logic [PUM_W-1:0]  row_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input logic [PUM_W-1:0] obs, input logic [PUM_W-1:0] exp);
    int w;
    vectors++;
    assert (obs === exp) else begin
      fails++;
      w = 0;
      for (int i = PUM_W/32 - 1; i >= 0; i--) if (obs[i*32 +: 32] !== exp[i*32 +: 32]) w = i;
      $error("FAIL %s: word %0d observed %h expected %h", tag, w, obs[w*32 +: 32], exp[w*32 +: 32]);
    end
  endtask

  function automatic logic [PUM_W-1:0] pat(input logic [31:0] base);
    logic [PUM_W-1:0] r;
    for (int i = 0; i < PUM_W/32; i++) r[i*32 +: 32] = base + 32'(i);
    return r;
  endfunction

  // exp_n: access-phase cycles before pready (1 = pready in the 2nd ACCESS cycle)
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input logic exp_err, input int exp_n);
    int n, rl;
    apb_exp_t e;
    e.data = exp_data; e.err = exp_err; e.chk_data = !wr;
    apb_q.push_back(e);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wdata;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    n = 0; rl = 0;
    while (1) begin
      #1;
      if (bus.pready === 1'b1) break;
      if (pum_mem_ready === 1'b0) rl++;
      n++;
      if (n > 64) break;
      @(posedge clk); #1;
    end
    last_rl = rl;
    chk("apb_pready", 64'(bus.pready), 64'(1));
    chk("apb_latency", 64'(n), 64'(exp_n));
    e = apb_q.pop_front();
    chk("apb_pslverr", 64'(bus.pslverr), 64'(e.err));
    if (e.chk_data) chk("apb_prdata", 64'(bus.prdata), 64'(e.data));
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
    #1;
    chk("apb_pready_drop", 64'(bus.pready), 64'(0));
  endtask

  task automatic pum_op(input logic rd, input logic wr, input logic [ROW_AW-1:0] row,
                        input logic [PUM_W-1:0] wd, input logic [PUM_W-1:0] exp_row);
    int n;
    @(posedge clk); #1;
    pum_mem_addr = row; pum_mem_wdata = wd; pum_mem_rd = rd; pum_mem_wr = wr;
    if (rd) row_q.push_back(exp_row);
    n = 0;
    #1;
    while (pum_mem_ready !== 1'b1 && n < 50) begin @(posedge clk); #2; n++; end
    chk("pum_ready", 64'(pum_mem_ready), 64'(1));
    @(posedge clk); #1;
    pum_mem_rd = 1'b0; pum_mem_wr = 1'b0;
    #1;
    if (rd) begin
      chk("pum_rvalid", 64'(pum_mem_rvalid), 64'(1));
      chk_row("pum_rdata", pum_mem_rdata, row_q.pop_front());
    end
  endtask

  logic [PUM_W-1:0] row5;

  initial begin
    rst_n = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0;
    pum_mem_addr = '0; pum_mem_wdata = '0; pum_mem_rd = 1'b0; pum_mem_wr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_pready", 64'(bus.pready), 64'(0));
    chk("rst_pslverr", 64'(bus.pslverr), 64'(0));
    chk("rst_prdata", 64'(bus.prdata), 64'(0));
    chk("rst_rvalid", 64'(pum_mem_rvalid), 64'(0));
    chk("rst_pum_ready", 64'(pum_mem_ready), 64'(1));

    apb_xfer(1'b1, 32'h0020_0008, 32'hDEAD_BEEF, 32'h0, 1'b0, 1);
    apb_xfer(1'b0, 32'h0020_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 1);
    apb_xfer(1'b0, 32'h0020_00A0, 32'h0, 32'h0, 1'b1, 1);

    row5 = pat(32'hA5A5_0000);
    pum_op(1'b0, 1'b1, 14'd5, row5, '0);
    repeat (3) pum_op(1'b1, 1'b0, 14'd5, '0, row5);

`ifdef PUM_APB_PERF_CNT_EN
    apb_xfer(1'b0, 32'h0020_0080, 32'h0, 32'd3, 1'b0, 1);
    apb_xfer(1'b0, 32'h0020_0084, 32'h0, 32'd1, 1'b0, 1);
    apb_xfer(1'b1, 32'h0020_0080, 32'h55, 32'h0, 1'b0, 1);
    apb_xfer(1'b0, 32'h0020_0080, 32'h0, 32'd3, 1'b0, 1);
`else
    apb_xfer(1'b0, 32'h0020_0080, 32'h0, 32'h0, 1'b1, 1);
`endif

    // row 5 col 9 -> word 169 -> byte address 0x2A4
    apb_xfer(1'b0, 32'h0000_02A4, 32'h0, 32'hA5A5_0009, 1'b0, 1);
    // row 5 col 17 (bank 2, lane 1) lane write, then whole-row PUM read
    apb_xfer(1'b1, 32'h0000_02C4, 32'h1234_5678, 32'h0, 1'b0, 1);
    row5[17*32 +: 32] = 32'h1234_5678;
    pum_op(1'b1, 1'b0, 14'd5, '0, row5);

    // PUM read held across an APB read: APB forced through after 8 stalls
    @(posedge clk); #1;
    pum_mem_addr = 14'd5; pum_mem_rd = 1'b1;
    apb_xfer(1'b0, 32'h0000_02A4, 32'h0, 32'hA5A5_0009, 1'b0, 9);
    chk("stall_ready_low_cycles", 64'(last_rl), 64'(1));
    chk("pum_resumes", 64'(pum_mem_ready), 64'(1));
    repeat (6) @(posedge clk);
    #1;
    pum_mem_rd = 1'b0;
`ifdef PUM_APB_PERF_CNT_EN
    apb_xfer(1'b0, 32'h0020_0088, 32'h0, 32'd1, 1'b0, 1);
`endif

    // read-before-write on row 3
    pum_op(1'b0, 1'b1, 14'd3, pat(32'h3333_0000), '0);
    pum_op(1'b1, 1'b1, 14'd3, pat(32'h7777_0000), pat(32'h3333_0000));
    pum_op(1'b1, 1'b0, 14'd3, '0, pat(32'h7777_0000));

    // reset while the FSM is in RESP
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'h0020_0008;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    chk("resp_pready", 64'(bus.pready), 64'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_resp_pready", 64'(bus.pready), 64'(0));
    chk("rst_resp_prdata", 64'(bus.prdata), 64'(0));
    chk("rst_resp_rvalid", 64'(pum_mem_rvalid), 64'(0));
    bus.psel = 1'b0; bus.penable = 1'b0;
    rst_n = 1'b1;
    apb_xfer(1'b0, 32'h0020_0008, 32'h0, 32'h0, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
